alu_cmd_issue: RTL and testbench

//   Command front end for the alu32 datapath. Buffers ALU commands {a, b, sel}
//   in an in-order FIFO and issues at most one command per clock to alu32.

---
 rtl/alu_cmd_issue.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: in-order command FIFO in front of the alu32 datapath.
// Commands {a, b, sel} are buffered, issued one per clock onto the
// registered alu_a/alu_b/alu_sel lines, and the alu32 result is collected
// after a fixed latency and returned together with a sequence tag.
// Optional feature: define ALU_ISSUE_CNT_EN to add the 32-bit issue_cnt
// output, a free-running count of issued commands.
module alu_cmd_issue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_sel,
  input  logic              issue_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic [CNT_W-1:0]  fifo_count
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [31:0]       issue_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [3:0]        mem_sel [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_cnt;

  // Stage k holds a command issued k edges ago. One stage more than ALU_LAT
  // is kept because alu32 registers its output: the result is sampled on the
  // edge after alu_out has settled.
  logic [ALU_LAT:0] pipe_valid;
  logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];

  logic push;
  logic pop;

  // in_ready deliberately ignores a same-cycle pop so it depends on state only.
  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid & in_ready;
  assign pop      = issue_en & (fifo_count != '0);

  // FIFO storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_sel[wr_ptr] <= in_sel;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue: load the alu32 operand registers from the FIFO head and advance the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      tag_cnt <= '0;
    end else if (pop) begin
      alu_a   <= mem_a[rd_ptr];
      alu_b   <= mem_b[rd_ptr];
      alu_sel <= mem_sel[rd_ptr];
      tag_cnt <= tag_cnt + TAG_W'(1);
    end
  end

  // Latency pipe of {valid, tag}; advances every edge and is flushed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i <= ALU_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_valid[0] <= pop;
      pipe_tag[0]   <= tag_cnt;
      for (int i = 1; i <= ALU_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // Result capture: pulse res_valid for one cycle and hold data/tag otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else if (pipe_valid[ALU_LAT]) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_tag   <= pipe_tag[ALU_LAT];
    end else begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  // Issue counter, wrapping from all-ones back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_cnt <= '0;
    else if (pop) issue_cnt <= issue_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: bench for alu_cmd_issue with a registered XOR stand-in
// for alu32, a queue-based reference model and a per-cycle compare process.
module tb_alu_cmd_issue;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [3:0]        in_sel;
  logic              issue_en;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic [CNT_W-1:0]  fifo_count;
`ifdef ALU_ISSUE_CNT_EN
  logic [31:0]       issue_cnt;
`endif

  alu_cmd_issue #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .issue_en(issue_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .fifo_count(fifo_count)
`ifdef ALU_ISSUE_CNT_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  // alu32 stand-in: registered XOR of the operands, one edge of latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_out <= '0;
    else        alu_out <= alu_a ^ alu_b;
  end

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  logic [TAG_W-1:0] seen_tags [$];

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        sel;
  } cmd_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } pend_t;

  // Reference model state: the FIFO as a queue, in-flight results as a
  // queue stamped with the edge number on which they must appear.
  cmd_t              mq [$];
  pend_t             pq [$];
  logic [DATA_W-1:0] m_a, m_b, m_rd;
  logic [3:0]        m_sel;
  logic              m_rv;
  logic [TAG_W-1:0]  m_rt, m_tag;
  logic [31:0]       m_cnt;
  int                cyc;

  // Model step on every rising edge; reset drops everything in flight.
  always @(posedge clk or negedge rst_n) begin
    bit   do_push;
    bit   do_pop;
    cmd_t c;
    if (!rst_n) begin
      mq.delete();
      pq.delete();
      m_a = '0; m_b = '0; m_sel = '0;
      m_rv = 1'b0; m_rd = '0; m_rt = '0;
      m_tag = '0; m_cnt = '0; cyc = 0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = issue_en && (mq.size() > 0);
      m_rv = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_rv = 1'b1;
        m_rd = pq[0].data;
        m_rt = pq[0].tag;
        void'(pq.pop_front());
      end
      if (do_pop) begin
        c = mq.pop_front();
        m_a = c.a; m_b = c.b; m_sel = c.sel;
        pq.push_back('{cyc + ALU_LAT + 1, c.a ^ c.b, m_tag});
        m_tag = m_tag + 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
      if (do_push) mq.push_back('{in_a, in_b, in_sel});
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [3:0] s,
                               input logic ie);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sel   = s;
    issue_en = ie;
  endtask

  // Compare every DUT output against the model on each falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready",   in_ready,   mq.size() < DEPTH);
      checkOutput("fifo_count", fifo_count, mq.size());
      checkOutput("alu_a",      alu_a,      m_a);
      checkOutput("alu_b",      alu_b,      m_b);
      checkOutput("alu_sel",    alu_sel,    m_sel);
      checkOutput("res_valid",  res_valid,  m_rv);
      checkOutput("res_data",   res_data,   m_rd);
      checkOutput("res_tag",    res_tag,    m_rt);
`ifdef ALU_ISSUE_CNT_EN
      checkOutput("issue_cnt",  issue_cnt,  m_cnt);
`endif
      if (res_valid) begin
        rv_count++;
        seen_tags.push_back(res_tag);
      end
    end
  end

  initial begin
    int rvc;
    applyStimulus(0, '0, '0, '0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single command latency: accept at E0, issue at E0+1, result after E0+3.
    @(negedge clk) applyStimulus(1, 32'd5, 32'd3, 4'b0001, 1);
    @(posedge clk);
    @(negedge clk) applyStimulus(0, '0, '0, '0, 1);
    checkOutput("lat_count_after_push", fifo_count, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_alu_a", alu_a, 5);
    checkOutput("lat_alu_b", alu_b, 3);
    checkOutput("lat_alu_sel", alu_sel, 1);
    checkOutput("lat_no_early_res", res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_still_no_res", res_valid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_res_valid", res_valid, 1);
    checkOutput("lat_res_data", res_data, 6);
    checkOutput("lat_res_tag", res_tag, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_pulse_ends", res_valid, 0);

    // Fill the FIFO with issue held off, then release issue with a 5th command waiting.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 32'(i + 10), 32'(i + 20), 4'(i), 0);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(1, 32'd99, 32'd1, 4'd2, 0);
    checkOutput("full_count", fifo_count, 4);
    checkOutput("full_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("full_held", fifo_count, 4);
    applyStimulus(1, 32'd99, 32'd1, 4'd2, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("full_pop_only", fifo_count, 3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("push_pop_same_edge", fifo_count, 3);
    applyStimulus(0, '0, '0, '0, 1);
    repeat (10) @(negedge clk);
    checkOutput("tag_seq_len", seen_tags.size(), 6);
    for (int i = 0; i < 6 && i < seen_tags.size(); i++)
      checkOutput($sformatf("tag_seq_%0d", i), seen_tags[i], i);

    // Asynchronous reset asserted mid-cycle clears outputs immediately.
    applyStimulus(1, 32'd7, 32'd9, 4'd3, 0);
    @(posedge clk);
    @(negedge clk) applyStimulus(1, 32'd8, 32'd8, 4'd4, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_sel", alu_sel, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_tag", res_tag, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk) applyStimulus(0, '0, '0, '0, 0);
    rst_n = 1'b1;

    // Reset with two commands in flight: neither may ever complete.
    @(negedge clk) applyStimulus(1, 32'd1, 32'd2, 4'd0, 1);
    @(posedge clk);
    @(negedge clk) applyStimulus(1, 32'd3, 32'd4, 4'd0, 1);
    @(posedge clk);
    @(negedge clk) applyStimulus(0, '0, '0, '0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    rvc = rv_count;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no_res_after_reset", rv_count, rvc);

`ifdef ALU_ISSUE_CNT_EN
    // Ten issues after reset give issue_cnt = 10.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'(i), 32'(i * 3), 4'(i), 1);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(0, '0, '0, '0, 1);
    repeat (3) @(negedge clk);
    checkOutput("issue_cnt_10", issue_cnt, 10);
`endif

    // Randomised traffic checked cycle by cycle against the model.
    repeat (3000) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6);
    end
    @(negedge clk) applyStimulus(0, '0, '0, '0, 1);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
